// File: rtl/iir_pkg.sv
// Shared constants for the time-multiplexed 5-section biquad IIR cascade.
//
// Contents:
//   DW, FRAC, ACC_W   sample/coefficient width, fractional bits, accumulator width
//   NUM_SEC, TAPS     section count and coefficients per section (b0 b1 b2 a1 a2)
//   ST_*              sequencer state encoding
//   SAT_MAX, SAT_MIN  Q2.14 saturation limits
//   coef_addr_of      ROM address of a given section/step pair
package iir_pkg;

    localparam int DW      = 16;
    localparam int FRAC    = 14;
    localparam int ACC_W   = 36;
    localparam int NUM_SEC = 5;
    localparam int TAPS    = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic signed [DW-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [DW-1:0] SAT_MIN = 16'sh8000;

    // Coefficients are stored section-major, so a section's five taps are
    // contiguous; the largest address produced is 4*5+4 = 24.
    function automatic logic [4:0] coef_addr_of(input logic [2:0] sec_idx,
                                                input logic [2:0] step_idx);
        return 5'(sec_idx) * 5'(TAPS) + 5'(step_idx);
    endfunction

endpackage

// File: rtl/iir_sat_shift.sv
// Rescales a Q4.28-style accumulator back to a Q2.14 sample.
//
// Ports:
//   acc   in   ACC_W  accumulator, signed two's complement
//   y     out  DW     acc >>> FRAC (floor), clipped to [SAT_MIN, SAT_MAX]
//   clip  out  1      high when the clipping changed the value
module iir_sat_shift
    import iir_pkg::*;
(
    input  logic [ACC_W-1:0] acc,
    output logic [DW-1:0]    y,
    output logic             clip
);

    localparam logic signed [ACC_W-1:0] MAX_EXT = ACC_W'(SAT_MAX);
    localparam logic signed [ACC_W-1:0] MIN_EXT = ACC_W'(SAT_MIN);

    logic signed [ACC_W-1:0] shifted;

    // The arithmetic shift floors toward minus infinity; the full-width
    // shifted value is compared against sign-extended limits so any guard
    // bits that disagree with the sample's sign bit are caught.
    always_comb begin
        shifted = $signed(acc) >>> FRAC;
        if (shifted > MAX_EXT) begin
            y    = SAT_MAX;
            clip = 1'b1;
        end else if (shifted < MIN_EXT) begin
            y    = SAT_MIN;
            clip = 1'b1;
        end else begin
            y    = shifted[DW-1:0];
            clip = 1'b0;
        end
    end

endmodule

// File: rtl/iir_cascade_seq.sv
// Sequencer and single shared MAC for a 5-section Direct Form I biquad
// cascade. One Q2.14 sample is accepted, pushed through every section one
// product per cycle, and the result is offered downstream.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst        in   1   asynchronous active-high reset
//   in_data    in   DW  input sample, Q2.14
//   in_valid   in   1   input sample valid
//   in_ready   out  1   high in IDLE only
//   out_data   out  DW  filtered sample, Q2.14, held while out_valid
//   out_valid  out  1   high in DONE only
//   out_ready  in  1    sink accepts out_data
//   coef_addr  out  5   coefficient ROM address, sec*TAPS+step
//   coef_in    in   DW  coefficient ROM data (combinational)
//   clr_state  in   1   in IDLE, zeroes every section's delay line
//   sat_flag   out  1   sticky saturation flag, only with IIR_SAT_FLAG_EN
//
// Optional build macro: IIR_SAT_FLAG_EN adds the sat_flag port.
module iir_cascade_seq
    import iir_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [4:0]    coef_addr,
    input  logic [DW-1:0] coef_in,
    input  logic          clr_state
`ifdef IIR_SAT_FLAG_EN
    ,
    output logic          sat_flag
`endif
);

    logic [1:0]              state;
    logic [2:0]              sec;
    logic [2:0]              step;
    logic [ACC_W-1:0]        acc;
    logic [ACC_W-1:0]        acc_next;
    logic [DW-1:0]           x_reg;
    logic [DW-1:0]           x1_mem [NUM_SEC];
    logic [DW-1:0]           x2_mem [NUM_SEC];
    logic [DW-1:0]           y1_mem [NUM_SEC];
    logic [DW-1:0]           y2_mem [NUM_SEC];
    logic [DW-1:0]           operand;
    logic signed [2*DW-1:0]  product;
    logic [ACC_W-1:0]        product_ext;
    logic [DW-1:0]           y_wb;
    logic                    clip;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    // The address is derived from the counters rather than registered, so it
    // naturally holds its last value while the counters are frozen in WB,
    // DONE and IDLE.
    assign coef_addr = coef_addr_of(sec, step);

    // The step counter picks which history term meets the current
    // coefficient; the order matches the ROM order b0 b1 b2 a1 a2.
    always_comb begin
        operand = x_reg;
        case (step)
            3'd0:    operand = x_reg;
            3'd1:    operand = x1_mem[sec];
            3'd2:    operand = x2_mem[sec];
            3'd3:    operand = y1_mem[sec];
            3'd4:    operand = y2_mem[sec];
            default: operand = x_reg;
        endcase
    end

    assign product     = $signed(coef_in) * $signed(operand);
    assign product_ext = {{(ACC_W-2*DW){product[2*DW-1]}}, product};

    // Feed-forward taps add, feedback taps subtract: y = b.x - a.y.
    assign acc_next = (step < 3'd3) ? (acc + product_ext) : (acc - product_ext);

    iir_sat_shift u_sat_shift (
        .acc  (acc),
        .y    (y_wb),
        .clip (clip)
    );

    // Sequencer plus the accumulator and section-input register. WB hands
    // the section output to the next section as its x and restarts the MAC,
    // or parks the final sample in out_data after the last section.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            sec      <= '0;
            step     <= '0;
            acc      <= '0;
            x_reg    <= '0;
            out_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_reg <= in_data;
                        acc   <= '0;
                        sec   <= '0;
                        step  <= '0;
                        state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc <= acc_next;
                    if (step == 3'd4) begin
                        state <= ST_WB;
                    end else begin
                        step <= step + 3'd1;
                    end
                end
                ST_WB: begin
                    x_reg <= y_wb;
                    acc   <= '0;
                    if (sec < 3'(NUM_SEC - 1)) begin
                        sec   <= sec + 3'd1;
                        step  <= '0;
                        state <= ST_MAC;
                    end else begin
                        out_data <= y_wb;
                        state    <= ST_DONE;
                    end
                end
                default: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Delay lines. A clear in IDLE takes effect on the same edge that may
    // accept a sample, so that sample starts from zeroed history; clears
    // requested in any other state are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SEC; i++) begin
                x1_mem[i] <= '0;
                x2_mem[i] <= '0;
                y1_mem[i] <= '0;
                y2_mem[i] <= '0;
            end
        end else if ((state == ST_IDLE) && clr_state) begin
            for (int i = 0; i < NUM_SEC; i++) begin
                x1_mem[i] <= '0;
                x2_mem[i] <= '0;
                y1_mem[i] <= '0;
                y2_mem[i] <= '0;
            end
        end else if (state == ST_WB) begin
            x2_mem[sec] <= x1_mem[sec];
            x1_mem[sec] <= x_reg;
            y2_mem[sec] <= y1_mem[sec];
            y1_mem[sec] <= y_wb;
        end
    end

`ifdef IIR_SAT_FLAG_EN
    // Sticky record that some section output was clipped since reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_flag <= 1'b0;
        end else if ((state == ST_WB) && clip) begin
            sat_flag <= 1'b1;
        end
    end
`else
    logic unused_clip;
    assign unused_clip = clip;
`endif

endmodule

// File: tb/tb_iir_cascade_seq.sv
// Self-checking bench for iir_cascade_seq. A bench-side ROM supplies
// coefficients (a realistic set, or a saturation set with only b0=0x7FFF);
// a behavioural DF1 model predicts each output, which is queued at accept
// time and popped when the DUT presents a sample.
module tb_iir_cascade_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  coef_addr;
    logic [15:0] coef_in;
    logic        clr_state;
`ifdef IIR_SAT_FLAG_EN
    logic        sat_flag;
`endif

    int          total = 0;
    int          bad = 0;
    int          cycleCount = 0;
    int          acceptCycle = 0;
    bit          romMode = 1'b0;
    bit          modelSat = 1'b0;
    logic [15:0] expQ[$];
    longint      hx1[5];
    longint      hx2[5];
    longint      hy1[5];
    longint      hy2[5];

    iir_cascade_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .coef_addr (coef_addr),
        .coef_in   (coef_in),
        .clr_state (clr_state)
`ifdef IIR_SAT_FLAG_EN
        ,
        .sat_flag  (sat_flag)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Bench coefficient ROM. b0=0x10E1 in every section reproduces the
    // impulse chain 0x10E1, 0x0473, 0x012C, 0x004F, 0x0014; b1 varies per
    // section so section addressing errors change the step response.
    function automatic logic [15:0] romWord(input logic [4:0] addr, input bit satRom);
        int s;
        int t;
        s = int'(addr) / 5;
        t = int'(addr) % 5;
        if (satRom) begin
            return (t == 0) ? 16'h7FFF : 16'h0000;
        end
        case (t)
            0:       return 16'h10E1;
            1:       return 16'h1800 + 16'(s * 256);
            2:       return 16'h0C00;
            3:       return 16'hE000;
            default: return 16'h0800;
        endcase
    endfunction

    assign coef_in = romWord(coef_addr, romMode);

    // Any stall longer than this means the bench or DUT is wedged.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic modelClear();
        for (int k = 0; k < 5; k++) begin
            hx1[k] = 0;
            hx2[k] = 0;
            hy1[k] = 0;
            hy2[k] = 0;
        end
    endtask

    function automatic longint coefOf(input int k, input int t);
        return longint'($signed(romWord(5'(k * 5 + t), romMode)));
    endfunction

    // Direct Form I reference: y = b0 x + b1 x1 + b2 x2 - a1 y1 - a2 y2,
    // floor-shifted by 14 and clipped to 16 bits, section by section.
    task automatic modelRun(input logic [15:0] s, output logic [15:0] r);
        longint xv;
        longint accv;
        longint yv;
        xv = longint'($signed(s));
        for (int k = 0; k < 5; k++) begin
            accv = coefOf(k, 0) * xv + coefOf(k, 1) * hx1[k] + coefOf(k, 2) * hx2[k]
                 - coefOf(k, 3) * hy1[k] - coefOf(k, 4) * hy2[k];
            yv = accv >>> 14;
            if (yv > 32767) begin
                yv = 32767;
                modelSat = 1'b1;
            end else if (yv < -32768) begin
                yv = -32768;
                modelSat = 1'b1;
            end
            hx2[k] = hx1[k];
            hx1[k] = xv;
            hy2[k] = hy1[k];
            hy1[k] = yv;
            xv = yv;
        end
        r = xv[15:0];
    endtask

    task automatic applyStimulus(input logic [15:0] s, input logic clr);
        int waitCnt;
        logic [15:0] r;
        waitCnt = 0;
        in_data = s;
        in_valid = 1'b1;
        clr_state = clr;
        while (!in_ready && waitCnt < 100) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!in_ready) begin
            checkEq("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            clr_state = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acceptCycle = cycleCount;
        if (clr) modelClear();
        modelRun(s, r);
        expQ.push_back(r);
        in_valid = 1'b0;
        clr_state = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input bit checkLat,
                               input bit useConst, input logic [15:0] constVal);
        int waitCnt;
        logic [15:0] expv;
        waitCnt = 0;
        @(negedge clk);
        while (!out_valid && waitCnt < 100) begin
            @(negedge clk);
            waitCnt++;
        end
        checkEq({tag, "_valid"}, 32'(out_valid), 32'd1);
        if (out_valid) begin
            if (expQ.size() == 0) begin
                checkEq({tag, "_queue"}, 32'(expQ.size()), 32'd1);
            end else begin
                expv = expQ.pop_front();
                checkEq(tag, 32'(out_data), 32'(expv));
            end
            if (useConst) checkEq({tag, "_const"}, 32'(out_data), 32'(constVal));
            if (checkLat) checkEq({tag, "_lat"}, 32'(cycleCount - acceptCycle), 32'd30);
`ifdef IIR_SAT_FLAG_EN
            checkEq({tag, "_satflag"}, 32'(sat_flag), 32'(modelSat));
`endif
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            checkEq({tag, "_drop"}, 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        logic [15:0] held;
        logic [15:0] r;
        int waitCnt;

        rst = 1'b1;
        in_data = '0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        clr_state = 1'b0;
        modelClear();

        repeat (2) @(negedge clk);
        checkEq("rst_in_ready", 32'(in_ready), 32'd1);
        checkEq("rst_out_valid", 32'(out_valid), 32'd0);
        checkEq("rst_out_data", 32'(out_data), 32'd0);
        checkEq("rst_coef_addr", 32'(coef_addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] impulse through the real ROM");
        applyStimulus(16'h4000, 1'b0);
        checkOutput("impulse", 1'b1, 1'b1, 16'h0014);

        $display("[TB] coefficient address trace");
        applyStimulus(16'h0000, 1'b0);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if ((k % 6) < 5) begin
                checkEq($sformatf("addr_k%0d", k), 32'(coef_addr), 32'((k / 6) * 5 + (k % 6)));
            end
        end
        checkOutput("trace", 1'b1, 1'b0, 16'h0000);

        $display("[TB] step input then history clear");
        for (int n = 0; n < 3; n++) begin
            applyStimulus(16'h4000, 1'b0);
            checkOutput($sformatf("step%0d", n), 1'b1, 1'b0, 16'h0000);
        end
        applyStimulus(16'h4000, 1'b1);
        checkOutput("clr_state", 1'b1, 1'b1, 16'h0014);

        $display("[TB] backpressure at DONE");
        applyStimulus(16'hC000, 1'b0);
        waitCnt = 0;
        while (!out_valid && waitCnt < 100) begin
            @(negedge clk);
            waitCnt++;
        end
        checkEq("bp_valid", 32'(out_valid), 32'd1);
        held = (expQ.size() > 0) ? expQ[0] : 16'hxxxx;
        in_data = 16'h2000;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checkEq($sformatf("bp_data%0d", i), 32'(out_data), 32'(held));
            checkEq($sformatf("bp_in_ready%0d", i), 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        checkEq("bp_still_valid", 32'(out_valid), 32'd1);
        if (expQ.size() > 0) void'(expQ.pop_front());
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkEq("bp_idle_ready", 32'(in_ready), 32'd1);
        checkEq("bp_idle_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        acceptCycle = cycleCount;
        modelRun(16'h2000, r);
        expQ.push_back(r);
        in_valid = 1'b0;
        checkEq("bp_accepted", 32'(in_ready), 32'd0);
        checkOutput("bp_next", 1'b1, 1'b0, 16'h0000);

        $display("[TB] reset during section 2");
        applyStimulus(16'h4000, 1'b0);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        checkEq("midrst_in_ready", 32'(in_ready), 32'd1);
        checkEq("midrst_out_valid", 32'(out_valid), 32'd0);
        checkEq("midrst_coef_addr", 32'(coef_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        expQ.delete();
        modelClear();
        modelSat = 1'b0;
        @(negedge clk);
        applyStimulus(16'h4000, 1'b0);
        checkOutput("after_rst", 1'b1, 1'b1, 16'h0014);

        $display("[TB] saturation ROM");
        romMode = 1'b1;
        applyStimulus(16'h7FFF, 1'b0);
        checkOutput("sat_pos", 1'b1, 1'b1, 16'h7FFF);
        applyStimulus(16'h8000, 1'b0);
        checkOutput("sat_neg", 1'b1, 1'b1, 16'h8000);
`ifdef IIR_SAT_FLAG_EN
        checkEq("sat_flag_set", 32'(sat_flag), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iir_cascade_seq.md
Name: iir_cascade_seq

Overview:
Time-multiplexed sequencer and single-MAC datapath for the 10th-order, 5-section biquad IIR cascade.
- Accepts one Q2.14 sample through a valid/ready handshake.
- Walks the shared multiplier-accumulator through every section, fetching coefficients from the coefficient ROM by address.
- Holds the Direct Form I delay lines for every section.
- Presents the filtered sample through a valid/ready handshake.
- Sits between the sample source and the downstream sink; the coefficient ROM hangs off its coef_addr/coef_in pair.

Parameters:
NUM_SEC, 5, number of biquad sections.
TAPS, 5, coefficients per section, in ROM order b0 b1 b2 a1 a2.
DW, 16, sample and coefficient width (signed two's complement).
FRAC, 14, fractional bits (Q2.14).
ACC_W, 36, accumulator width (2*DW plus 4 guard bits).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
in_data  in  DW  input sample, Q2.14 signed.
in_valid  in  1  input sample valid.
in_ready  out  1  block can accept a sample.
out_data  out  DW  filtered sample, Q2.14 signed.
out_valid  out  1  out_data valid.
out_ready  in  1  sink accepts out_data.
coef_addr  out  5  ROM address, sec*TAPS+step, range 0..24.
coef_in  in  DW  ROM data, combinational response to coef_addr.
clr_state  in  1  synchronous clear of all delay lines.

Behaviour:
- Reset (async, rst=1): FSM=IDLE; in_ready=1, out_valid=0, out_data=0, coef_addr=0; all delay lines, accumulator, section and step counters zero.
- FSM states IDLE, MAC, WB, DONE.
- IDLE:
  - in_ready=1.
  - in_valid&in_ready latches in_data as section input x, clears acc, sets sec=0, step=0, goes to MAC.
  - clr_state=1 in IDLE zeroes every x1/x2/y1/y2. If in_valid is also 1, the clear applies first and the sample is still accepted with zeroed history.
  - clr_state is ignored outside IDLE.
- MAC:
  - One product per cycle: coef_addr = sec*5+step; operand = x, x1, x2, y1, y2 for steps 0..4.
  - Steps 0..2 add the product to acc; steps 3..4 subtract it.
  - Step 4 goes to WB.
- WB (one cycle):
  - y = acc >>> FRAC (arithmetic shift, floor), saturated to [0x8000, 0x7FFF].
  - Update: x2<=x1, x1<=x, y2<=y1, y1<=y, all for this section.
  - x<=y as the next section's input; acc cleared.
  - sec<NUM_SEC-1: sec++, step=0, back to MAC. Otherwise out_data<=y and go to DONE.
- DONE:
  - out_valid=1; out_data held stable until out_ready=1.
  - On out_ready=1: out_valid drops next cycle, go to IDLE.
  - in_ready stays 0 until IDLE.
- Latency: accept edge to out_valid rise = NUM_SEC*(TAPS+1) = 30 cycles. Throughput is one sample per 31 cycles minimum (32 including the IDLE accept cycle).
- coef_addr holds its last value during WB/DONE/IDLE. The value is don't-care there but is never outside 0..24.
- Products are full 32-bit Q4.28 values, sign-extended into ACC_W. No intermediate saturation.

Optional Feature:
IIR_SAT_FLAG_EN
- Defined: adds output port sat_flag (1 bit). It is a sticky flag set in any WB cycle where saturation clipped y. It is cleared only by rst.
- Undefined: the port and its logic are absent; saturation behaviour is identical.

Decomposition:
- Shared package iir_pkg: DW, FRAC, ACC_W, NUM_SEC, TAPS, the FSM state encoding, and the saturation limits 0x7FFF/0x8000.
- One natural sub-module: iir_sat_shift, a combinational ACC_W→DW arithmetic shift plus saturate. It outputs y and a clip bit.

Test Plan:
- Impulse, real ROM: after reset send 0x4000 → out_data=0x0014 (per-section y: 0x10E1, 0x0473, 0x012C, 0x004F, 0x0014); out_valid exactly 30 cycles after accept.
- Address trace: one sample → coef_addr sequence 0..4, hold, 5..9, hold, … 20..24, each value valid in its MAC cycle only.
- Saturation, bench ROM with all b0=0x7FFF and all others 0: input 0x7FFF → out_data=0x7FFF; input 0x8000 → out_data=0x8000; sat_flag=1 when the macro is defined.
- Backpressure: hold out_ready=0 for 10 cycles at DONE → out_data stable, in_ready=0, a new in_valid is not accepted; release → IDLE next cycle, then accepted.
- Reset mid-operation: assert rst during the section-2 MAC → in_ready=1 and out_valid=0 immediately; the next impulse 0x4000 gives 0x0014 (history cleared).
- clr_state: run a 0x4000 step for 3 samples, pulse clr_state with in_valid=0x4000 in IDLE → output equals the first-sample impulse result 0x0014.
